// File: rtl/alu8_seq32.sv
// Byte-serial sequencer around the combinational alu8: runs one W-bit ADD/SUB/AND/OR
// as BYTES LSB-first slices, chaining status. Optional zero flag: ALU8_SEQ_ZERO_FLAG_EN.
module alu8_seq32 #(
    parameter int BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [8*BYTES-1:0]   a,
    input  logic [8*BYTES-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [8*BYTES-1:0]   y,
    output logic                 carry_out,
`ifdef ALU8_SEQ_ZERO_FLAG_EN
    output logic                 zero,
`endif
    output logic [1:0]           state_dbg,
    output logic [7:0]           alu_left,
    output logic [7:0]           alu_right,
    output logic                 alu_status_in,
    output logic [1:0]           alu_opcode,
    input  logic                 alu_status_out,
    input  logic [7:0]           alu_result
);

    localparam int W  = 8 * BYTES;
    localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  a_q, b_q;
    logic [1:0]    op_q;
    logic [IW-1:0] idx;
    logic          chain;
    logic          accept;
    logic [W-1:0]  y_final;

    // Handshake: start is accepted on a rising edge whenever busy is low (IDLE or DONE);
    // busy is high exactly while slices run; done is a single-cycle pulse after which y
    // and carry_out are valid and held until the next accepted start. Start while busy is dropped.
    assign accept    = start && (state != S_RUN);
    assign state_dbg = state;
    assign y_final   = {alu_result, y[W-9:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        alu_left      = 8'd0;
        alu_right     = 8'd0;
        alu_status_in = 1'b0;
        alu_opcode    = 2'd0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy          = 1'b1;
                alu_left      = a_q[8*idx +: 8];
                alu_right     = b_q[8*idx +: 8];
                alu_status_in = chain;
                alu_opcode    = op_q;
                if (idx == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 2'd0;
            idx       <= '0;
            chain     <= 1'b0;
            y         <= '0;
            carry_out <= 1'b0;
`ifdef ALU8_SEQ_ZERO_FLAG_EN
            zero      <= 1'b0;
`endif
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            idx   <= '0;
            chain <= 1'b0;
        end else if (state == S_RUN) begin
            y[8*idx +: 8] <= alu_result;
            chain         <= alu_status_out;
            idx           <= idx + 1'b1;
            if (idx == LAST) begin
                // Logic ops may report anything on status_out; only arithmetic carries out.
                carry_out <= op_q[1] ? 1'b0 : alu_status_out;
`ifdef ALU8_SEQ_ZERO_FLAG_EN
                zero      <= (y_final == '0);
`endif
                idx       <= '0;
            end
        end
    end

`ifndef ALU8_SEQ_ZERO_FLAG_EN
    logic unused_y_final;
    assign unused_y_final = ^y_final;
`endif

endmodule

// File: tb/tb_alu8_seq32.sv
// Directed bench for alu8_seq32 with a behavioural alu8 attached to the alu_* ports.
// Build with +define+ALU8_SEQ_ZERO_FLAG_EN to also check the zero flag.
module tb_alu8_seq32;

    localparam int BYTES = 4;
    localparam int W     = 8 * BYTES;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, carry_out;
    logic [W-1:0] y;
    logic [1:0]   state_dbg;
    logic [7:0]   alu_left, alu_right, alu_result;
    logic         alu_status_in, alu_status_out;
    logic [1:0]   alu_opcode;
    logic [8:0]   sum9;
`ifdef ALU8_SEQ_ZERO_FLAG_EN
    logic         zero;
`endif

    int total;
    int bad;
    logic [W-1:0] exp_q[$];

    alu8_seq32 #(.BYTES(BYTES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .op             (op),
        .a              (a),
        .b              (b),
        .busy           (busy),
        .done           (done),
        .y              (y),
        .carry_out      (carry_out),
`ifdef ALU8_SEQ_ZERO_FLAG_EN
        .zero           (zero),
`endif
        .state_dbg      (state_dbg),
        .alu_left       (alu_left),
        .alu_right      (alu_right),
        .alu_status_in  (alu_status_in),
        .alu_opcode     (alu_opcode),
        .alu_status_out (alu_status_out),
        .alu_result     (alu_result)
    );

    // alu8 model; logic ops report status_out=1 so carry_out masking is visible.
    always_comb begin
        sum9 = 9'd0;
        case (alu_opcode)
            2'd0:    sum9 = {1'b0, alu_left} + {1'b0, alu_right} + {8'd0, alu_status_in};
            2'd1:    sum9 = {1'b0, alu_left} - {1'b0, alu_right} - {8'd0, alu_status_in};
            2'd2:    sum9 = {1'b1, alu_left & alu_right};
            default: sum9 = {1'b1, alu_left | alu_right};
        endcase
        alu_result     = sum9[7:0];
        alu_status_out = sum9[8];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] ey, input logic ec,
                          input logic ez);
        int edges;
        int busy_cnt;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = av; b = bv;
        edges = 0; busy_cnt = 0;
        do begin
            @(posedge clk); #1;
            if (edges == 0) begin
                start = 1'b0;
                chk({tag, "_cin0"}, 64'(alu_status_in), 64'(0));
                chk({tag, "_left0"}, 64'(alu_left), 64'(av[7:0]));
            end
            edges++;
            if (busy) busy_cnt++;
        end while (!done && edges < 40);
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_lat"}, 64'(edges), 64'(BYTES + 1));
        chk({tag, "_busy"}, 64'(busy_cnt), 64'(BYTES));
        chk({tag, "_y"}, 64'(y), 64'(ey));
        chk({tag, "_carry"}, 64'(carry_out), 64'(ec));
`ifdef ALU8_SEQ_ZERO_FLAG_EN
        chk({tag, "_zero"}, 64'(zero), 64'(ez));
`else
        if (ez === 1'bx) $display("zero flag not built");
`endif
        chk({tag, "_idle_alu"}, 64'({alu_left, alu_right}), 64'(0));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(done), 64'(0));
        chk({tag, "_hold"}, 64'(y), 64'(ey));
    endtask

    initial begin
        int pulses;
        int first_done;
        int second_done;
        int edges;
        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_y", 64'(y), 64'(0));
        chk("rst_carry", 64'(carry_out), 64'(0));
        chk("rst_alu", 64'({alu_left, alu_right, alu_status_in, alu_opcode}), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        run_op("add_ff_1",  2'd0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
        run_op("add_wrap",  2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);
        run_op("sub_100_1", 2'd1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0);
        run_op("sub_under", 2'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("and_aa55",  2'd2, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b1);
        run_op("or_aa55",   2'd3, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("add_mix",   2'd0, 32'h89AB_CDEF, 32'h7654_3211, 32'h0000_0000, 1'b1, 1'b1);

        // start while busy must be dropped, not queued
        @(posedge clk); #1;
        start = 1'b1; op = 2'd0; a = 32'h0000_0001; b = 32'h0000_0002;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; op = 2'd1; a = 32'h0000_0100; b = 32'h0000_0100;
        @(posedge clk); #1; start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                pulses++;
                chk("ign_y", 64'(y), 64'(32'h0000_0003));
            end
            @(posedge clk); #1;
        end
        chk("ign_pulses", 64'(pulses), 64'(1));
        chk("ign_idle", 64'(busy), 64'(0));

        // asynchronous reset at byte index 2 aborts the operation
        @(posedge clk); #1;
        start = 1'b1; op = 2'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_alu_live", 64'(alu_left), 64'(8'hFF));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 64'(busy), 64'(0));
        chk("ar_done", 64'(done), 64'(0));
        chk("ar_y", 64'(y), 64'(0));
        chk("ar_alu", 64'({alu_left, alu_right, alu_status_in, alu_opcode}), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("ar_no_done", 64'(pulses), 64'(0));
        run_op("add_post", 2'd0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0);

        // start held through DONE: second op begins with no IDLE cycle
        exp_q.push_back(32'h1112_1314);
        exp_q.push_back(32'h0F0F_00F0);
        @(posedge clk); #1;
        start = 1'b1; op = 2'd0; a = 32'h0102_0304; b = 32'h1010_1010;
        first_done = 0; second_done = 0; pulses = 0; edges = 0;
        while (edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                op = 2'd3; a = 32'h0F0F_0000; b = 32'h0000_00F0;
            end
            if (first_done != 0 && edges == first_done + 1) begin
                chk("b2b_no_idle", 64'(busy), 64'(1));
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                if (pulses == 1) first_done = edges;
                else second_done = edges;
                if (exp_q.size() != 0) chk("b2b_y", 64'(y), 64'(exp_q.pop_front()));
            end
        end
        start = 1'b0;
        chk("b2b_pulses", 64'(pulses), 64'(2));
        chk("b2b_gap", 64'(second_done - first_done), 64'(BYTES + 1));
        chk("b2b_q_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
